// File: rtl/mixcol_engine.sv
// AES MixColumns / InvMixColumns engine streaming 128-bit state words through a
// single-port SRAM: read a word, transform its four columns, write it back out.
//   state     | meaning
//   S_IDLE    | waiting for start; operands latched here
//   S_READ    | read strobe for block k
//   S_WAIT    | read latency padding (RD_LAT-1 cycles)
//   S_CAPTURE | transform the returned word into res_q
//   S_WRITE   | write strobe for block k, then advance
//   S_DONE    | one-cycle completion pulse
module mixcol_engine #(
  parameter int ADDR_WIDTH  = 16,
  parameter int CNT_WIDTH   = 4,
  parameter int RD_LAT      = 2,
  parameter int ADDR_STRIDE = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  inv_i,
  input  logic [ADDR_WIDTH-1:0] src_addr_i,
  input  logic [ADDR_WIDTH-1:0] dst_addr_i,
  input  logic [CNT_WIDTH-1:0]  count_i,
  input  logic [127:0]          sramReadValue_i,
  output logic                  sramRead_o,
  output logic                  sramWrite_o,
  output logic [ADDR_WIDTH-1:0] sramAddr_o,
  output logic [127:0]          sramWriteValue_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_CAPTURE,
    S_WRITE,
    S_DONE
  } state_t;

  localparam int WAIT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = (RD_LAT > 2) ? WAIT_W'(RD_LAT - 2) : '0;
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(ADDR_STRIDE);

  state_t                state_q, state_d;
  logic                  inv_q, inv_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  k_q, k_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [127:0]          res_q, res_d;
  logic [CNT_WIDTH:0]    k_inc;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // Row 0 is the most significant byte of the column.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    if (inv) begin
      r0 = mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3);
      r1 = mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3);
      r2 = muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3);
      r3 = mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3);
    end else begin
      r0 = xtime(a0) ^ mul3(a1) ^ a2 ^ a3;
      r1 = a0 ^ xtime(a1) ^ mul3(a2) ^ a3;
      r2 = a0 ^ a1 ^ xtime(a2) ^ mul3(a3);
      r3 = mul3(a0) ^ a1 ^ a2 ^ xtime(a3);
    end
    return {r0, r1, r2, r3};
  endfunction

  function automatic logic [127:0] mix_word(input logic [127:0] w, input logic inv);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = mix_col(w[127-32*c -: 32], inv);
    end
    return o;
  endfunction

  assign k_inc = {1'b0, k_q} + (CNT_WIDTH + 1)'(1);

  always_comb begin
    state_d          = state_q;
    inv_d            = inv_q;
    rd_addr_d        = rd_addr_q;
    wr_addr_d        = wr_addr_q;
    cnt_d            = cnt_q;
    k_d              = k_q;
    wait_d           = wait_q;
    res_d            = res_q;
    sramRead_o       = 1'b0;
    sramWrite_o      = 1'b0;
    sramAddr_o       = '0;
    sramWriteValue_o = '0;
    busy_o           = (state_q != S_IDLE);
    done_o           = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          inv_d     = inv_i;
          rd_addr_d = src_addr_i;
          wr_addr_d = dst_addr_i;
          cnt_d     = count_i;
          k_d       = '0;
          state_d   = (count_i == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        sramRead_o = 1'b1;
        sramAddr_o = rd_addr_q;
        if (RD_LAT > 1) begin
          wait_d  = WAIT_LOAD;
          state_d = S_WAIT;
        end else begin
          state_d = S_CAPTURE;
        end
      end
      S_WAIT: begin
        if (wait_q == '0) state_d = S_CAPTURE;
        else              wait_d  = wait_q - WAIT_W'(1);
      end
      S_CAPTURE: begin
        res_d   = mix_word(sramReadValue_i, inv_q);
        state_d = S_WRITE;
      end
      S_WRITE: begin
        sramWrite_o      = 1'b1;
        sramAddr_o       = wr_addr_q;
        sramWriteValue_o = res_q;
        k_d              = k_inc[CNT_WIDTH-1:0];
        rd_addr_d        = rd_addr_q + STRIDE;
        wr_addr_d        = wr_addr_q + STRIDE;
        state_d          = (k_inc < {1'b0, cnt_q}) ? S_READ : S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      inv_q     <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      cnt_q     <= '0;
      k_q       <= '0;
      wait_q    <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      inv_q     <= inv_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      wait_q    <= wait_d;
      res_q     <= res_d;
    end
  end

endmodule

// File: tb/tb_mixcol_engine.sv
// Bench for mixcol_engine: three instances (RD_LAT 1, 2, 4) share stimulus, each
// with its own SRAM and a cycle-schedule reference model checked every cycle.
module tb_mixcol_engine;

  localparam int NI = 3;
  localparam logic [127:0] TV_A = 128'hdb135345_f20a225c_01010101_2d26314c;
  localparam logic [127:0] TV_B = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, inv;
  logic [15:0] src, dst;
  logic [3:0]  cnt;

  logic         rd_w[NI], wr_w[NI], busy_w[NI], done_w[NI];
  logic [15:0]  addr_w[NI];
  logic [127:0] wv_w[NI], rv_w[NI];
  logic [127:0] pipe[NI][4];

  logic [127:0] sram[int];
  logic [127:0] refm[int];

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    mixcol_engine #(.ADDR_WIDTH(16), .CNT_WIDTH(4), .RD_LAT(L), .ADDR_STRIDE(1)) u_dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .inv_i(inv),
      .src_addr_i(src), .dst_addr_i(dst), .count_i(cnt),
      .sramReadValue_i(rv_w[g]),
      .sramRead_o(rd_w[g]), .sramWrite_o(wr_w[g]), .sramAddr_o(addr_w[g]),
      .sramWriteValue_o(wv_w[g]), .busy_o(busy_w[g]), .done_o(done_w[g])
    );
    assign rv_w[g] = pipe[g][L-1];
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
  endfunction

  function automatic int key(input int i, input logic [15:0] a);
    return (i << 16) | int'(a);
  endfunction

  function automatic logic [127:0] init_word(input logic [15:0] a);
    logic [31:0] x;
    x = 32'(a) * 32'h9E3779B1;
    return {x, x ^ 32'h85EBCA6B, ~x, x[15:0], x[31:16]};
  endfunction

  function automatic logic [127:0] sram_rd(input int i, input logic [15:0] a);
    return sram.exists(key(i, a)) ? sram[key(i, a)] : init_word(a);
  endfunction

  function automatic logic [127:0] ref_rd(input int i, input logic [15:0] a);
    return refm.exists(key(i, a)) ? refm[key(i, a)] : init_word(a);
  endfunction

  // Generic GF(2^8) multiply, modulus 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int n = 0; n < 8; n++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] mixcol_ref(input logic [127:0] w, input logic iv);
    logic [7:0] co[4];
    logic [7:0] col[4];
    logic [7:0] o;
    logic [127:0] res;
    res = '0;
    if (iv) co = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else    co = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) col[r] = w[127-32*c-8*r -: 8];
      for (int r = 0; r < 4; r++) begin
        o = 8'h00;
        for (int j = 0; j < 4; j++) o = o ^ gmul(co[(j - r + 4) % 4], col[j]);
        res[127-32*c-8*r -: 8] = o;
      end
    end
    return res;
  endfunction

  // Reference model: an accepted start fixes a schedule of offsets from E0.
  bit           act[NI];
  int           off[NI], lcn[NI];
  logic         lin[NI];
  logic [15:0]  lsrc[NI], ldst[NI];
  logic [127:0] expw[NI];
  int           cyc = 0;
  logic         pre_en = 1'b0;
  logic [15:0]  pre_a = '0;
  logic [127:0] pre_v = '0;

  always @(posedge clk) begin
    int L, bl, b, ph;
    cyc = cyc + 1;
    for (int i = 0; i < NI; i++) begin
      if (pre_en) begin
        sram[key(i, pre_a)] = pre_v;
        refm[key(i, pre_a)] = pre_v;
      end
      if (wr_w[i] === 1'b1) sram[key(i, addr_w[i])] = wv_w[i];
      for (int s = 3; s > 0; s--) pipe[i][s] <= pipe[i][s-1];
      pipe[i][0] <= (rd_w[i] === 1'b1) ? sram_rd(i, addr_w[i])
                                         : {$urandom, $urandom, $urandom, $urandom};
      L  = lat_of(i);
      bl = L + 2;
      if (rst) begin
        act[i] = 1'b0;
      end else if (act[i]) begin
        if (off[i] == lcn[i] * bl) begin
          act[i] = 1'b0;
        end else begin
          b  = off[i] / bl;
          ph = off[i] % bl;
          if (ph == 0) expw[i] = mixcol_ref(ref_rd(i, 16'(lsrc[i] + b)), lin[i]);
          if (ph == bl - 1) refm[key(i, 16'(ldst[i] + b))] = expw[i];
          off[i] = off[i] + 1;
        end
      end else if (start) begin
        act[i]  = 1'b1;
        off[i]  = 0;
        lin[i]  = inv;
        lsrc[i] = src;
        ldst[i] = dst;
        lcn[i]  = int'(cnt);
      end
    end
  end

  int           vectors = 0, miscompares = 0, nprint = 0;
  bit           check_en = 1'b0;
  int           e0 = 0;
  int           n_rd[NI], n_wr[NI], n_busy[NI], last_done[NI];
  logic [127:0] last_wr_val[NI];
  logic [15:0]  last_wr_addr[NI];
  logic [16:0]  trace[$];

  task automatic check_all();
    int L, bl, last, o, b, ph;
    logic er, ew, eb, ed;
    logic [15:0] ea;
    logic [127:0] ev;
    for (int i = 0; i < NI; i++) begin
      L = lat_of(i); bl = L + 2; last = lcn[i] * bl; o = off[i]; b = o / bl; ph = o % bl;
      er = act[i] && (o < last) && (ph == 0);
      ew = act[i] && (o < last) && (ph == bl - 1);
      ea = er ? 16'(lsrc[i] + b) : (ew ? 16'(ldst[i] + b) : 16'h0000);
      ev = ew ? expw[i] : 128'h0;
      eb = act[i];
      ed = act[i] && (o == last);
      vectors++;
      if (rd_w[i] !== er || wr_w[i] !== ew || addr_w[i] !== ea || wv_w[i] !== ev ||
          busy_w[i] !== eb || done_w[i] !== ed) begin
        miscompares++;
        if (nprint < 20) begin
          nprint++;
          $display("FAIL cycle_check cyc%0d lat%0d: got rd=%b wr=%b addr=%h wv=%h busy=%b done=%b, need rd=%b wr=%b addr=%h wv=%h busy=%b done=%b",
                   cyc, L, rd_w[i], wr_w[i], addr_w[i], wv_w[i], busy_w[i], done_w[i],
                   er, ew, ea, ev, eb, ed);
        end
      end
      if (wr_w[i] === 1'b1) begin
        n_wr[i]++;
        last_wr_val[i]  = wv_w[i];
        last_wr_addr[i] = addr_w[i];
        if (i == 1) trace.push_back({1'b1, addr_w[i]});
      end
      if (rd_w[i] === 1'b1) begin
        n_rd[i]++;
        if (i == 1) trace.push_back({1'b0, addr_w[i]});
      end
      if (done_w[i] === 1'b1) last_done[i] = cyc;
      if (busy_w[i] === 1'b1) n_busy[i]++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (check_en) check_all();
  endtask

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h need %h", nm, got, want);
    end
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < NI; i++) if (busy_w[i] !== 1'b0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 600; t++) begin
      if (all_idle()) begin ok = 1'b1; break; end
      tick();
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL idle_timeout: busy still high after 600 cycles at cyc%0d", cyc);
    end
  endtask

  task automatic do_start(input logic iv, input logic [15:0] s, input logic [15:0] d,
                          input logic [3:0] c);
    start = 1'b1; inv = iv; src = s; dst = d; cnt = c;
    e0 = cyc + 1;
    for (int i = 0; i < NI; i++) last_done[i] = -1;
    tick();
    start = 1'b0;
    inv = 1'($urandom); src = 16'($urandom); dst = 16'($urandom); cnt = 4'($urandom);
  endtask

  task automatic preload(input logic [15:0] a, input logic [127:0] v);
    pre_a = a; pre_v = v; pre_en = 1'b1;
    tick();
    pre_en = 1'b0;
  endtask

  initial begin
    int snap_rd[NI], snap_wr[NI], snap_busy[NI];
    logic [16:0] exp_tr[6];
    int n;
    logic [15:0] s, d;

    rst = 1'b1; start = 1'b0; inv = 1'b0; src = '0; dst = '0; cnt = '0;
    for (int i = 0; i < NI; i++) begin
      n_rd[i] = 0; n_wr[i] = 0; n_busy[i] = 0; last_done[i] = -1;
      last_wr_val[i] = '0; last_wr_addr[i] = '0;
    end
    repeat (3) tick();
    check_en = 1'b1;
    tick();
    for (int i = 0; i < NI; i++) begin
      chk("reset_busy", busy_w[i], 0);
      chk("reset_wv", wv_w[i], 0);
    end
    rst = 1'b0;
    tick();

    chk("model_fwd", mixcol_ref(TV_A, 1'b0), TV_B);
    chk("model_inv", mixcol_ref(TV_B, 1'b1), TV_A);

    // Forward, then inverse, on one known word in place at 0x0020.
    preload(16'h0020, TV_A);
    do_start(1'b0, 16'h0020, 16'h0020, 4'd1);
    wait_idle();
    for (int i = 0; i < NI; i++) begin
      chk("fwd_value", last_wr_val[i], TV_B);
      chk("fwd_addr", last_wr_addr[i], 16'h0020);
      chk("fwd_done_lat", last_done[i] - e0, lat_of(i) + 2);
    end
    do_start(1'b1, 16'h0020, 16'h0020, 4'd1);
    wait_idle();
    for (int i = 0; i < NI; i++) chk("inv_value", last_wr_val[i], TV_A);

    // Three blocks with source wrap at 0xFFFF.
    trace.delete();
    do_start(1'b0, 16'hFFFF, 16'h0100, 4'd3);
    wait_idle();
    exp_tr = '{{1'b0, 16'hFFFF}, {1'b1, 16'h0100}, {1'b0, 16'h0000},
               {1'b1, 16'h0101}, {1'b0, 16'h0001}, {1'b1, 16'h0102}};
    chk("wrap_trace_len", trace.size(), 6);
    for (int t = 0; t < 6; t++)
      if (t < trace.size()) chk("wrap_trace", trace[t], exp_tr[t]);
    for (int i = 0; i < NI; i++) chk("wrap_done_lat", last_done[i] - e0, 3 * (lat_of(i) + 2));

    // count = 0
    for (int i = 0; i < NI; i++) begin
      snap_rd[i] = n_rd[i]; snap_wr[i] = n_wr[i]; snap_busy[i] = n_busy[i];
    end
    do_start(1'b1, 16'h1234, 16'h4321, 4'd0);
    wait_idle();
    for (int i = 0; i < NI; i++) begin
      chk("zero_reads", n_rd[i] - snap_rd[i], 0);
      chk("zero_writes", n_wr[i] - snap_wr[i], 0);
      chk("zero_busy_cycles", n_busy[i] - snap_busy[i], 1);
      chk("zero_done_lat", last_done[i] - e0, 0);
    end

    // Reset during WAIT of block 2 (RD_LAT=2 instance).
    for (int i = 0; i < NI; i++) snap_wr[i] = n_wr[i];
    do_start(1'b0, 16'h0200, 16'h0300, 4'd3);
    while (cyc < e0 + 5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NI; i++) chk("abort_busy", busy_w[i], 0);
    chk("abort_writes_lat1", n_wr[0] - snap_wr[0], 2);
    chk("abort_writes_lat2", n_wr[1] - snap_wr[1], 1);
    chk("abort_writes_lat4", n_wr[2] - snap_wr[2], 1);
    tick();
    do_start(1'b0, 16'h0200, 16'h0400, 4'd2);
    wait_idle();
    for (int i = 0; i < NI; i++) chk("after_abort_done_lat", last_done[i] - e0, 2 * (lat_of(i) + 2));

    // start pulsed during each instance's first WRITE with other inv/count.
    for (int tgt = 0; tgt < NI; tgt++) begin
      for (int i = 0; i < NI; i++) snap_wr[i] = n_wr[i];
      do_start(1'b0, 16'h0500, 16'h0600, 4'd2);
      while (cyc < e0 + lat_of(tgt) + 1) tick();
      start = 1'b1; inv = 1'b1; cnt = 4'd5;
      tick();
      start = 1'b0;
      wait_idle();
      for (int i = 0; i < NI; i++) begin
        chk("busy_start_writes", n_wr[i] - snap_wr[i], 2);
        chk("busy_start_done_lat", last_done[i] - e0, 2 * (lat_of(i) + 2));
      end
    end

    // start held high: back-to-back operations.
    start = 1'b1; inv = 1'b0; src = 16'h0700; dst = 16'h0700; cnt = 4'd2;
    repeat (50) tick();
    start = 1'b0;
    wait_idle();

    // Randomized operations with stray start pulses and occasional resets.
    for (int it = 0; it < 120; it++) begin
      s = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'(16'hFFFF - $urandom_range(0, 4));
      d = ($urandom_range(0, 3) == 0) ? s : 16'($urandom);
      do_start(1'($urandom), s, d, 4'($urandom_range(0, 6)));
      n = $urandom_range(2, 30);
      for (int t = 0; t < n; t++) begin
        if ($urandom_range(0, 7) == 0) begin
          start = 1'b1; inv = 1'($urandom); src = 16'($urandom);
          dst = 16'($urandom); cnt = 4'($urandom_range(0, 6));
        end else begin
          start = 1'b0;
        end
        rst = ($urandom_range(0, 199) == 0);
        tick();
      end
      start = 1'b0;
      rst = 1'b0;
      wait_idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
